// File: rtl/uart_img_frame_loader.sv
// uart_img_frame_loader: parses a framed RGB565 image stream from UART bytes into RAM writes.
// Frame: A5 5A, IMG_W*IMG_H pixels (hi byte first), then an 8-bit sum of all pixel bytes.
module uart_img_frame_loader #(
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 256,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [15:0]       ram_wrdata,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic              err_timeout
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, SYNC2, HI, LO, CSUM} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pix_cnt;
    logic [7:0]        csum, hi_byte;
    logic [TO_W-1:0]   to_cnt;
    logic              do_wr, do_done, do_err, do_tmo;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A received byte always wins over an expiring timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        do_wr     = 1'b0;
        do_done   = 1'b0;
        do_err    = 1'b0;
        do_tmo    = 1'b0;
        if (rx_done) begin
            case (state)
                IDLE:  state_nxt = (rx_data == 8'hA5) ? SYNC2 : IDLE;
                SYNC2: state_nxt = (rx_data == 8'h5A) ? HI : (rx_data == 8'hA5) ? SYNC2 : IDLE;
                HI:    state_nxt = LO;
                LO: begin
                    do_wr     = 1'b1;
                    state_nxt = (pix_cnt == LAST_PIX) ? CSUM : HI;
                end
                CSUM: begin
                    do_done   = 1'b1;
                    do_err    = (rx_data != csum);
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TO_LAST) begin
            state_nxt = IDLE;
            do_err    = 1'b1;
            do_tmo    = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ram_wren    <= 1'b0;
            ram_wraddr  <= '0;
            ram_wrdata  <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_timeout <= 1'b0;
            pix_cnt     <= '0;
            csum        <= '0;
            hi_byte     <= '0;
            to_cnt      <= '0;
        end else begin
            ram_wren   <= do_wr;
            frame_done <= do_done;
            frame_err  <= do_err;
            busy       <= (state_nxt != IDLE);
            to_cnt     <= (rx_done || state_nxt == IDLE) ? '0 : to_cnt + 1'b1;
            if (do_err) err_timeout <= do_tmo;
            if (do_wr) begin
                ram_wraddr <= pix_cnt;
                ram_wrdata <= {hi_byte, rx_data};
            end
            if (rx_done) begin
                if (state == SYNC2 && rx_data == 8'h5A) begin
                    pix_cnt <= '0;
                    csum    <= '0;
                end
                if (state == HI) begin
                    hi_byte <= rx_data;
                    csum    <= csum + rx_data;
                end
                if (state == LO) begin
                    csum    <= csum + rx_data;
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_img_frame_loader.sv
// tb_uart_img_frame_loader: randomized frame-level bench for the UART image frame loader.
module tb_uart_img_frame_loader;
    localparam int IMG_W = 4, IMG_H = 2, ADDR_W = 16, TOC = 100;
    localparam int NPIX = IMG_W * IMG_H;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_done = 1'b0;
    logic              ram_wren, busy, frame_done, frame_err, err_timeout;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [15:0]       ram_wrdata;

    int vecs = 0, errs = 0;

    logic              s_wr, s_fd, s_fe, s_et, s_bz, n_wr, n_fd, n_fe, g_ev;
    logic [ADDR_W-1:0] s_ad;
    logic [15:0]       s_dt;

    uart_img_frame_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TOC)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .rx_data(rx_data), .rx_done(rx_done),
        .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .err_timeout(err_timeout)
    );

    always #5 Clk = ~Clk;

    // One byte strobe; captures outputs right after the strobe edge, the edge after, and any event in the rest of the gap.
    task automatic strobe(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge Clk); #1;
        rx_done = 1'b0;
        s_wr = ram_wren; s_ad = ram_wraddr; s_dt = ram_wrdata;
        s_fd = frame_done; s_fe = frame_err; s_et = err_timeout; s_bz = busy;
        @(posedge Clk); #1;
        n_wr = ram_wren; n_fd = frame_done; n_fe = frame_err;
        g_ev = 1'b0;
        repeat (gap - 1) begin
            @(posedge Clk); #1;
            g_ev = g_ev | ram_wren | frame_done | frame_err;
        end
    endtask

    task automatic test_frame(input string nm, input logic [15:0] px[NPIX], input bit bad, input int race);
        logic [7:0] b[2*NPIX+3];
        logic [7:0] sum = 8'h00;
        b[0] = 8'hA5;
        b[1] = 8'h5A;
        for (int i = 0; i < NPIX; i++) begin
            b[2+2*i] = px[i][15:8];
            b[3+2*i] = px[i][7:0];
            sum = sum + px[i][15:8] + px[i][7:0];
        end
        b[2*NPIX+2] = sum + 8'(bad);
        for (int j = 0; j < 2*NPIX+3; j++) begin
            strobe(b[j], (j + 1 == race) ? TOC - 1 : 9);
            if (j >= 2 && j < 2*NPIX+2) begin
                int p = (j - 2) / 2;
                if ((j - 2) % 2 == 1) begin
                    vecs++;
                    if (s_wr !== 1'b1 || s_ad !== ADDR_W'(p) || s_dt !== px[p]) begin
                        errs++;
                        $display("FAIL %s write p%0d: got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=%h", nm, p, s_wr, s_ad, s_dt, p, px[p]);
                    end
                end else begin
                    vecs++;
                    if (s_wr !== 1'b0 || (p > 0 && s_ad !== ADDR_W'(p - 1))) begin
                        errs++;
                        $display("FAIL %s hi-byte p%0d: got wr=%b addr=%0d want wr=0 addr held", nm, p, s_wr, s_ad);
                    end
                end
            end
            if (j < 2*NPIX+2) begin
                vecs++;
                if (s_fd !== 1'b0 || s_fe !== 1'b0 || s_bz !== 1'b1 || (j < 2 && s_wr !== 1'b0)) begin
                    errs++;
                    $display("FAIL %s byte%0d flags: got fd=%b fe=%b busy=%b wr=%b want 0 0 1 0", nm, j, s_fd, s_fe, s_bz, s_wr);
                end
            end else begin
                vecs++;
                if (s_fd !== 1'b1 || s_fe !== bad || (bad && s_et !== 1'b0) || s_bz !== 1'b0 || s_wr !== 1'b0) begin
                    errs++;
                    $display("FAIL %s end: got fd=%b fe=%b et=%b busy=%b wr=%b want fd=1 fe=%b busy=0 wr=0", nm, s_fd, s_fe, s_et, s_bz, s_wr, bad);
                end
            end
            vecs++;
            if (n_wr !== 1'b0 || n_fd !== 1'b0 || n_fe !== 1'b0 || g_ev !== 1'b0) begin
                errs++;
                $display("FAIL %s byte%0d pulse: got next wr=%b fd=%b fe=%b gap_ev=%b want all 0", nm, j, n_wr, n_fd, n_fe, g_ev);
            end
        end
    endtask

    task automatic rand_px(output logic [15:0] px[NPIX]);
        for (int i = 0; i < NPIX; i++) px[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        vecs++;
        if ({ram_wren, ram_wraddr, ram_wrdata, busy, frame_done, frame_err, err_timeout} !== '0) begin
            errs++;
            $display("FAIL reset: got wr=%b addr=%h data=%h busy=%b fd=%b fe=%b et=%b want all 0", ram_wren, ram_wraddr, ram_wrdata, busy, frame_done, frame_err, err_timeout);
        end
        Reset_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_good_frame();
        logic [15:0] px[NPIX];
        px[0] = 16'h1234;
        for (int i = 1; i < NPIX; i++) px[i] = 16'(i);
        test_frame("good", px, 1'b0, -1);
        rand_px(px);
        test_frame("good_rand", px, 1'b0, -1);
    endtask

    task automatic test_bad_csum();
        logic [15:0] px[NPIX];
        rand_px(px);
        test_frame("bad_csum", px, 1'b1, -1);
    endtask

    task automatic test_resync();
        logic [15:0] px[NPIX];
        strobe(8'h00, 9);
        vecs++;
        if (s_bz !== 1'b0) begin errs++; $display("FAIL resync_00 busy: got %b want 0", s_bz); end
        strobe(8'hA5, 9);
        vecs++;
        if (s_bz !== 1'b1) begin errs++; $display("FAIL resync_a5 busy: got %b want 1", s_bz); end
        rand_px(px);
        test_frame("resync", px, 1'b0, -1);
        strobe(8'hA5, 9);
        strobe(8'h11, 9);
        vecs++;
        if (s_bz !== 1'b0 || s_wr !== 1'b0) begin errs++; $display("FAIL resync_11: got busy=%b wr=%b want 0 0", s_bz, s_wr); end
        strobe(8'h5A, 9);
        vecs++;
        if (s_bz !== 1'b0 || s_wr !== 1'b0 || n_wr !== 1'b0 || g_ev !== 1'b0) begin
            errs++;
            $display("FAIL resync_5a: got busy=%b wr=%b ev=%b want 0 0 0", s_bz, s_wr, g_ev);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] px[NPIX];
        logic [15:0] p0 = 16'($urandom);
        int k = 1;
        bit hit = 0;
        strobe(8'hA5, 9);
        strobe(8'h5A, 9);
        strobe(p0[15:8], 9);
        strobe(p0[7:0], 9);
        vecs++;
        if (s_wr !== 1'b1 || s_ad !== '0 || s_dt !== p0) begin
            errs++;
            $display("FAIL timeout_write: got wr=%b addr=%0d data=%h want 1 0 %h", s_wr, s_ad, s_dt, p0);
        end
        strobe(8'($urandom), 1);
        hit = n_fe;
        while (!hit && k < 3 * TOC) begin
            @(posedge Clk); #1;
            k++;
            hit = frame_err;
        end
        vecs++;
        if (k != TOC || !hit) begin
            errs++;
            $display("FAIL timeout_cycle: got abort at cycle %0d (seen=%b) want cycle %0d", k, hit, TOC);
        end
        vecs++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || ram_wren !== 1'b0) begin
            errs++;
            $display("FAIL timeout_flags: got et=%b busy=%b fd=%b wr=%b want 1 0 0 0", err_timeout, busy, frame_done, ram_wren);
        end
        @(posedge Clk); #1;
        vecs++;
        if (frame_err !== 1'b0) begin errs++; $display("FAIL timeout_pulse: got fe=%b want 0", frame_err); end
        repeat (5) @(posedge Clk);
        #1;
        rand_px(px);
        test_frame("after_timeout", px, 1'b0, -1);
        vecs++;
        if (err_timeout !== 1'b1) begin errs++; $display("FAIL et_hold: got %b want 1", err_timeout); end
    endtask

    task automatic test_race();
        logic [15:0] px[NPIX];
        rand_px(px);
        test_frame("race_lo", px, 1'b0, 5);
        rand_px(px);
        test_frame("race_csum", px, 1'b0, 2*NPIX+2);
    endtask

    task automatic test_reset_mid();
        logic [15:0] px[NPIX];
        strobe(8'hA5, 9);
        strobe(8'h5A, 9);
        for (int i = 0; i < 5; i++) begin
            strobe(8'($urandom), 9);
            strobe(8'($urandom), 9);
        end
        vecs++;
        if (busy !== 1'b1 || ram_wraddr !== ADDR_W'(4)) begin
            errs++;
            $display("FAIL pre_reset: got busy=%b addr=%0d want 1 4", busy, ram_wraddr);
        end
        Reset_n = 1'b0;
        #2;
        vecs++;
        if ({ram_wren, ram_wraddr, ram_wrdata, busy, frame_done, frame_err, err_timeout} !== '0) begin
            errs++;
            $display("FAIL reset_mid: got wr=%b addr=%h data=%h busy=%b fd=%b fe=%b et=%b want all 0", ram_wren, ram_wraddr, ram_wrdata, busy, frame_done, frame_err, err_timeout);
        end
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        rand_px(px);
        test_frame("after_reset", px, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_resync();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/uart_img_frame_loader.md
Name: uart_img_frame_loader

Overview:
- Sits between the UART byte receiver and the dual-port image RAM, on the write side of the RAM.
- Parses a framed image stream from the received bytes: sync header, IMG_W*IMG_H RGB565 pixels sent high byte first, then an 8-bit checksum.
- Assembles each pixel and issues one RAM write per pixel. The display side reads the same RAM independently.
- Reports frame completion, checksum failure and inter-byte timeout. Runs entirely in the system clock domain.

Parameters:
- IMG_W, 256, pixels per line.
- IMG_H, 256, lines per frame.
- ADDR_W, 16, RAM write address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- TIMEOUT_CYC, 500000, Clk cycles without rx_done inside a frame before the frame is aborted (10 ms at 50 MHz).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid when rx_done=1.
- rx_done  in  1  single-cycle byte strobe; consecutive strobes are at least 2 cycles apart.
- ram_wren  out  1  single-cycle RAM write enable.
- ram_wraddr  out  ADDR_W  pixel address, row-major, starting at 0.
- ram_wrdata  out  16  RGB565 pixel {hi_byte, lo_byte}.
- busy  out  1  high while a frame is in progress (state != IDLE).
- frame_done  out  1  single-cycle pulse when a frame ends, good or bad checksum.
- frame_err  out  1  single-cycle pulse on checksum mismatch or timeout.
- err_timeout  out  1  qualifies frame_err: 1=timeout, 0=checksum; holds its value until the next frame_err.

Behaviour:
- Reset: every output is 0; state=IDLE; pixel counter, checksum accumulator, hi-byte latch and timeout counter are 0. Reset is honoured mid-frame: the partial frame is abandoned and no further writes occur.
- All outputs are registered. Bytes are acted on only in cycles where rx_done=1.
- IDLE:
  - rx_data=0xA5 -> SYNC2.
  - Any other byte: ignored, stay in IDLE.
- SYNC2:
  - 0x5A -> HI; pixel counter and checksum are cleared.
  - 0xA5 -> stay in SYNC2.
  - Any other byte -> IDLE.
- HI: latch byte as the high byte; checksum += byte (mod 256); -> LO.
- LO: checksum += byte (mod 256).
  - In the cycle after rx_done: ram_wren=1, ram_wraddr=pixel counter, ram_wrdata={hi,byte}. Write latency is exactly 1 cycle after the low-byte strobe.
  - Pixel counter increments with the write.
  - If the counter was IMG_W*IMG_H-1 -> CSUM, else -> HI.
- ram_wraddr and ram_wrdata hold their last values while ram_wren=0. No write is issued for header or checksum bytes.
- CSUM:
  - On the byte strobe, compare the byte with the accumulated checksum.
  - The next cycle: frame_done=1. If they differ, also frame_err=1 and err_timeout=0.
  - -> IDLE.
  - Pixels already written stay in RAM; no rollback.
- Timeout:
  - In any state except IDLE, the counter increments each cycle and clears on rx_done.
  - When it reaches TIMEOUT_CYC-1 with no rx_done: -> IDLE, frame_err=1, err_timeout=1, frame_done stays 0, counter cleared.
  - If rx_done arrives in the same cycle the count expires, rx_done wins: the byte is processed and the counter clears.
  - The counter is held at 0 in IDLE.
- A new header byte 0xA5 arriving in HI/LO/CSUM is treated as data, never as resync.
- Counter widths: pixel counter is ADDR_W bits; timeout counter is wide enough for TIMEOUT_CYC.

Test Plan (sim parameters IMG_W=4, IMG_H=2, TIMEOUT_CYC=100; bytes spaced 10 cycles apart):
- Good frame: A5 5A, then pixels 0x1234, 0x0001 … 0x0007 sent as byte pairs, then the correct sum byte -> 8 writes, addr 0..7, data 0x1234 then 0x0001..0x0007. Each write occurs 1 cycle after its low-byte strobe. frame_done=1 once, frame_err never asserts, busy falls with frame_done.
- Bad checksum: same frame with checksum+1 -> same 8 writes; frame_done and frame_err pulse in the same cycle; err_timeout=0.
- Header resync: bytes 00 A5 A5 5A then the frame -> first write goes to addr 0. Bytes A5 11 5A -> stays in IDLE, no writes, busy=0.
- Timeout: header plus 3 bytes, then silence -> one write (addr 0). After 100 cycles: frame_err=1, err_timeout=1, busy=0, frame_done=0. A following good frame completes normally from addr 0.
- Timeout race: rx_done asserted exactly on the expiring cycle -> no abort; the byte is accepted and the frame completes.
- Reset mid-frame: Reset_n low after 5 pixels -> all outputs 0 immediately. After release, a full frame writes addr 0..7.
